// File: rtl/pwm_capture.sv
// PWM capture: measures high time and period per rising-edge frame, with a timeout report for flat inputs.
// Optional input debounce is enabled by defining PWM_CAP_FILTER_EN.
module pwm_capture #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd4000,
    parameter int unsigned FILTER_LEN     = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        pwm_in,
    output logic [31:0] high_time,
    output logic [31:0] period,
    output logic        valid,
    output logic        timeout,
    output logic        level
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  sync_q, sync_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] hi_cnt_q, hi_cnt_d;
    logic [31:0] high_time_q, high_time_d;
    logic [31:0] period_q, period_d;
    logic        valid_q, valid_d;
    logic        timeout_q, timeout_d;
    logic        level_q, level_d;

    logic        lvl;
    logic        lvl_prev;
    logic        rise;

    // sync_q[0] = s0, sync_q[1] = s1, sync_q[2] = s2
    assign sync_d = {sync_q[1:0], pwm_in};

`ifdef PWM_CAP_FILTER_EN
    localparam int RUN_W = $clog2(FILTER_LEN + 1);

    logic             deb_q, deb_d;
    logic             deb_dly_q, deb_dly_d;
    logic [RUN_W-1:0] run_q, run_d;

    // Debounced level flips only after FILTER_LEN consecutive samples disagree with it.
    always_comb begin
        deb_d     = deb_q;
        run_d     = '0;
        deb_dly_d = deb_q;
        if (sync_q[1] != deb_q) begin
            if (run_q == RUN_W'(FILTER_LEN - 1)) begin
                deb_d = sync_q[1];
            end else begin
                run_d = run_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            deb_q     <= 1'b0;
            deb_dly_q <= 1'b0;
            run_q     <= '0;
        end else begin
            deb_q     <= deb_d;
            deb_dly_q <= deb_dly_d;
            run_q     <= run_d;
        end
    end

    assign lvl      = deb_q;
    assign lvl_prev = deb_dly_q;
`else
    assign lvl      = sync_q[1];
    assign lvl_prev = sync_q[2];
`endif

    assign rise = lvl & ~lvl_prev;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hi_cnt_d    = hi_cnt_q;
        high_time_d = high_time_q;
        period_d    = period_q;
        valid_d     = 1'b0;
        timeout_d   = timeout_q;
        level_d     = level_q;

        if (!enable) begin
            state_d  = IDLE;
            cnt_d    = '0;
            hi_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d    = '0;
                    hi_cnt_d = '0;
                    state_d  = ARM;
                end
                ARM: begin
                    if (rise) begin
                        cnt_d    = 32'd1;
                        hi_cnt_d = 32'd1;
                        state_d  = MEASURE;
                    end
                end
                MEASURE: begin
                    // An edge takes priority over a coincident timeout.
                    if (rise) begin
                        period_d    = cnt_q;
                        high_time_d = hi_cnt_q;
                        timeout_d   = 1'b0;
                        valid_d     = 1'b1;
                        cnt_d       = 32'd1;
                        hi_cnt_d    = 32'd1;
                    end else if (cnt_q == TIMEOUT_CYCLES) begin
                        period_d    = TIMEOUT_CYCLES;
                        high_time_d = lvl ? TIMEOUT_CYCLES : 32'd0;
                        level_d     = lvl;
                        timeout_d   = 1'b1;
                        valid_d     = 1'b1;
                        cnt_d       = '0;
                        hi_cnt_d    = '0;
                        state_d     = ARM;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                        if (lvl) begin
                            hi_cnt_d = hi_cnt_q + 32'd1;
                        end
                    end
                end
                default: begin
                    state_d  = IDLE;
                    cnt_d    = '0;
                    hi_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            sync_q      <= '0;
            cnt_q       <= '0;
            hi_cnt_q    <= '0;
            high_time_q <= '0;
            period_q    <= '0;
            valid_q     <= 1'b0;
            timeout_q   <= 1'b0;
            level_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            cnt_q       <= cnt_d;
            hi_cnt_q    <= hi_cnt_d;
            high_time_q <= high_time_d;
            period_q    <= period_d;
            valid_q     <= valid_d;
            timeout_q   <= timeout_d;
            level_q     <= level_d;
        end
    end

    assign high_time = high_time_q;
    assign period    = period_q;
    assign valid     = valid_q;
    assign timeout   = timeout_q;
    assign level     = level_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: stimulus tasks push expected reports, a negedge monitor pops and compares.
module tb_pwm_capture;

    localparam logic [31:0] TO = 32'd4000;
`ifdef PWM_CAP_FILTER_EN
    localparam int TOG = 4;
`else
    localparam int TOG = 1;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        pwm_in = 1'b0;
    logic [31:0] high_time;
    logic [31:0] period;
    logic        valid;
    logic        timeout;
    logic        level;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] per;
        logic        to;
        logic        lv;
    } rep_t;

    rep_t exp_q[$];
    logic model_level = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pwm_capture #(
        .TIMEOUT_CYCLES(TO),
        .FILTER_LEN    (3)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .pwm_in   (pwm_in),
        .high_time(high_time),
        .period   (period),
        .valid    (valid),
        .timeout  (timeout),
        .level    (level)
    );

    always @(negedge clk) begin
        rep_t e;
        if (!reset && valid) begin
            $display("valid: high_time=%0d period=%0d timeout=%0b level=%0b",
                     high_time, period, timeout, level);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid: got high_time=%0d period=%0d timeout=%0b, required no valid",
                         high_time, period, timeout);
            end else begin
                e = exp_q.pop_front();
                if ({high_time, period, timeout, level} !== e) begin
                    errors++;
                    $display("FAIL report: got hi=%0d per=%0d to=%0b lv=%0b, required hi=%0d per=%0d to=%0b lv=%0b",
                             high_time, period, timeout, level, e.hi, e.per, e.to, e.lv);
                end
            end
        end
    end

    task automatic hold(input logic v, input int n);
        pwm_in = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic push_edge(input int hi, input int per);
        rep_t r;
        r.hi  = 32'(hi);
        r.per = 32'(per);
        r.to  = 1'b0;
        r.lv  = model_level;
        exp_q.push_back(r);
    endtask

    task automatic push_timeout(input logic lv);
        rep_t r;
        model_level = lv;
        r.hi  = lv ? TO : 32'd0;
        r.per = TO;
        r.to  = 1'b1;
        r.lv  = lv;
        exp_q.push_back(r);
    endtask

    // n rising edges; the first only arms, each later one closes a hi/lo frame.
    task automatic run_wave(input int hi, input int lo, input int n);
        for (int i = 0; i < n; i++) begin
            if (i > 0) push_edge(hi, hi + lo);
            hold(1'b1, hi);
            hold(1'b0, lo);
        end
    endtask

    task automatic rearm();
        pwm_in = 1'b0;
        enable = 1'b0;
        repeat (5) @(negedge clk);
        enable = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d reports still pending, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({high_time, period, valid, timeout, level} !== 67'd0) begin
            errors++;
            $display("FAIL reset_outputs: got hi=%0d per=%0d v=%0b to=%0b lv=%0b, required all 0",
                     high_time, period, valid, timeout, level);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_frames();
        rearm();
        run_wave(250, 750, 3);
    endtask

    task automatic test_timeout_low();
        push_timeout(1'b0);
        hold(1'b0, 3500);
        drain("timeout_low");
        run_wave(100, 400, 3);
        drain("after_timeout");
    endtask

    task automatic test_timeout_high();
        rearm();
        run_wave(100, 400, 2);
        push_edge(100, 500);
        push_timeout(1'b1);
        hold(1'b1, 4100);
        drain("timeout_high");
    endtask

    task automatic test_enable_abort();
        rearm();
        run_wave(250, 750, 2);
        push_edge(250, 1000);
        hold(1'b1, 100);
        enable = 1'b0;
        hold(1'b1, 50);
        checks++;
        if (high_time !== 32'd250 || period !== 32'd1000 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL enable_hold: got hi=%0d per=%0d to=%0b, required hi=250 per=1000 to=0",
                     high_time, period, timeout);
        end
        enable = 1'b1;
        hold(1'b1, 100);
        hold(1'b0, 750);
        run_wave(250, 750, 3);
        drain("enable_abort");
    endtask

    task automatic test_async_reset();
        rearm();
        run_wave(250, 750, 2);
        push_edge(250, 1000);
        hold(1'b1, 100);
        drain("pre_reset");
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({high_time, period, valid, timeout, level} !== 67'd0) begin
            errors++;
            $display("FAIL async_reset: got hi=%0d per=%0d v=%0b to=%0b lv=%0b, required all 0",
                     high_time, period, valid, timeout, level);
        end
        model_level = 1'b0;
        pwm_in = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        hold(1'b0, 5);
        run_wave(TOG, TOG, 6);
        drain("after_reset");
    endtask

    task automatic test_glitch();
        rearm();
        for (int i = 0; i < 3; i++) begin
`ifdef PWM_CAP_FILTER_EN
            if (i > 0) push_edge(500, 1000);
`else
            if (i > 0) push_edge(298, 798);
`endif
            if (i < 2) begin
                hold(1'b1, 200);
`ifndef PWM_CAP_FILTER_EN
                push_edge(200, 202);
`endif
                hold(1'b0, 2);
                hold(1'b1, 298);
            end else begin
                hold(1'b1, 500);
            end
            hold(1'b0, 500);
        end
        drain("glitch");
    endtask

    initial begin
        test_reset();
        test_frames();
        test_timeout_low();
        test_timeout_high();
        test_enable_abort();
        test_async_reset();
        test_glitch();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
